// File: rtl/fetch_sequencer.sv
// Fetch address sequencer: sequential fetch, redirects with a one-cycle
// flush bubble, and a circular return-address stack for call/ret.
module fetch_sequencer #(
    parameter logic [9:0] RESET_ADDR = 10'h000,
    parameter int         RAS_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       stall,
    input  logic       branch_taken,
    input  logic [9:0] branch_target,
    input  logic       jump,
    input  logic       call,
    input  logic [9:0] jump_target,
    input  logic       ret,
    output logic [9:0] instruction_address,
    output logic       fetch_valid,
    output logic       ras_overflow,
    output logic       ras_underflow
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

    typedef enum logic [1:0] {
        INIT,
        RUN,
        FLUSH
    } state_t;

    state_t      state;
    logic [9:0]  ras [RAS_DEPTH];
    logic [PW-1:0] ptr;
    logic [PW:0] count;
    logic [9:0]  next_seq;
    logic [PW-1:0] top;

    assign next_seq = instruction_address + 10'd1;
    assign top      = ptr - PW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= INIT;
            instruction_address <= RESET_ADDR;
            fetch_valid         <= 1'b0;
            ptr                 <= '0;
            count               <= '0;
            ras_overflow        <= 1'b0;
            ras_underflow       <= 1'b0;
        end else begin
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
            unique case (state)
                INIT: begin
                    state               <= RUN;
                    instruction_address <= RESET_ADDR;
                    fetch_valid         <= 1'b1;
                end
                FLUSH: begin
                    state       <= RUN;
                    fetch_valid <= 1'b1;
                end
                RUN: begin
                    if (stall) begin
                        fetch_valid <= 1'b0;
                    end else if (ret && count != '0) begin
                        instruction_address <= ras[top];
                        ptr                 <= top;
                        count               <= count - (PW+1)'(1);
                        state               <= FLUSH;
                        fetch_valid         <= 1'b0;
                    end else if (ret) begin
                        instruction_address <= next_seq;
                        fetch_valid         <= 1'b1;
                        ras_underflow       <= 1'b1;
                    end else if (call) begin
                        // Wrapping ptr overwrites the oldest entry when full
                        ras[ptr] <= next_seq;
                        ptr      <= ptr + PW'(1);
                        if (count == FULL)
                            ras_overflow <= 1'b1;
                        else
                            count <= count + (PW+1)'(1);
                        instruction_address <= jump_target;
                        state               <= FLUSH;
                        fetch_valid         <= 1'b0;
                    end else if (jump) begin
                        instruction_address <= jump_target;
                        state               <= FLUSH;
                        fetch_valid         <= 1'b0;
                    end else if (branch_taken) begin
                        instruction_address <= branch_target;
                        state               <= FLUSH;
                        fetch_valid         <= 1'b0;
                    end else begin
                        instruction_address <= next_seq;
                        fetch_valid         <= 1'b1;
                    end
                end
                default: begin
                    state       <= INIT;
                    fetch_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
